// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the 5-stage pipeline sequencer.
// Holds the FSM state encodings, the named control-output vectors and the
// default flush depth / stall limit used by pipe_seq_ctrl.
package pipe_ctrl_pkg;

    // FSM states; the encoding is visible externally through state_dbg.
    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_STALL   = 3'd1,
        ST_FLUSH   = 3'd2,
        ST_MEMWAIT = 3'd3,
        ST_HALT    = 3'd4,
        ST_ERROR   = 3'd5
    } state_t;

    // Pipeline control bundle, MSB first as listed.
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_write;
        logic idex_bubble;
        logic exmem_hold;
    } ctl_t;

    // Normal advance of every stage.
    localparam ctl_t CTL_RUN    = ctl_t'(6'b110100);
    // Mispredict / flush: fetch the corrected target, squash IF/ID and ID/EX.
    localparam ctl_t CTL_SQUASH = ctl_t'(6'b111110);
    // Memory wait: freeze the whole pipe, back end held.
    localparam ctl_t CTL_HOLD   = ctl_t'(6'b000001);
    // Hazard stall: front end frozen, bubble into EX.
    localparam ctl_t CTL_STALL  = ctl_t'(6'b000110);
    // Halt / error drain: front end frozen, back end keeps retiring.
    localparam ctl_t CTL_DRAIN  = ctl_t'(6'b000110);
    // Reset: NOPs loaded into IF/ID and ID/EX, PC frozen.
    localparam ctl_t CTL_RESET  = ctl_t'(6'b001110);

    localparam int DEF_FLUSH_DEPTH = 2;
    localparam int DEF_STALL_LIMIT = 8;

    // State to return to after a memory wait; STALL is resumed as RUN so the
    // hazard is re-evaluated from scratch.
    function automatic state_t ret_of(input state_t cur, input state_t saved);
        state_t r;
        case (cur)
            ST_MEMWAIT: r = saved;
            ST_STALL:   r = ST_RUN;
            default:    r = cur;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the sequencer performance counters.
// Ports: clock, reset (sync, active-high), inc (count enable),
//        count (current value; sticks at all-ones, never wraps).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;

    // Count register: clears on reset, increments until all-ones.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= {W{1'b0}};
        end else if (inc && (count_r != {W{1'b1}})) begin
            count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/pipe_seq_ctrl.sv
// Central sequencer for the 16-bit 5-stage pipeline.
// Arbitrates mem_busy > mispredict > flush-in-progress > hazard_stall > halt_req
// and sequences multi-cycle flushes, memory waits and halt/drain.
// Ports:
//   clock, reset (sync, active-high)
//   hazard_stall, mispredict, mem_busy, halt_req, resume : event inputs
//   pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_hold :
//       same-cycle pipeline controls (combinational from state and inputs)
//   state_dbg   : current FSM state
//   stall_count : hazard-stall cycles (saturating)
//   flush_count : mispredict events (saturating)
//   error       : sticky consecutive-stall-limit violation
module pipe_seq_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_DEPTH = DEF_FLUSH_DEPTH,
    parameter int STALL_LIMIT = DEF_STALL_LIMIT,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             hazard_stall,
    input  logic             mispredict,
    input  logic             mem_busy,
    input  logic             halt_req,
    input  logic             resume,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             exmem_hold,
    output logic [2:0]       state_dbg,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             error
);

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_DEPTH - 1);
    localparam logic [7:0] LIMIT_8      = 8'(STALL_LIMIT);

    state_t     state_r, ret_r;
    logic [2:0] flush_left_r;
    logic [7:0] consec_r;
    logic       error_r;

    state_t     state_nxt_s, ret_nxt_s, eff_s;
    logic [2:0] flush_left_nxt_s;
    logic [7:0] consec_nxt_s;
    logic       err_set_s;
    logic       stall_inc_s;
    logic       flush_inc_s;
    ctl_t       ctl_s;

    // Next-state, bookkeeping and control-output decode.
    always_comb begin
        ctl_s            = CTL_RUN;
        state_nxt_s      = state_r;
        ret_nxt_s        = ret_r;
        flush_left_nxt_s = flush_left_r;
        consec_nxt_s     = consec_r;
        err_set_s        = 1'b0;
        stall_inc_s      = 1'b0;
        flush_inc_s      = 1'b0;
        // Leaving MEMWAIT acts with the saved state's rules in the same cycle.
        eff_s            = (state_r == ST_MEMWAIT) ? ret_r : state_r;

        if (reset) begin
            ctl_s = CTL_RESET;
        end else if (mem_busy) begin
            // Everything frozen; flush_left and consec keep their values.
            ctl_s       = CTL_HOLD;
            state_nxt_s = ST_MEMWAIT;
            ret_nxt_s   = ret_of(state_r, ret_r);
        end else begin
            case (eff_s)
                ST_ERROR: begin
                    ctl_s       = CTL_DRAIN;
                    state_nxt_s = ST_ERROR;
                end
                ST_HALT: begin
                    ctl_s = CTL_DRAIN;
                    if (resume) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_HALT;
                    end
                end
                ST_RUN, ST_STALL, ST_FLUSH: begin
                    if (mispredict) begin
                        ctl_s            = CTL_SQUASH;
                        flush_left_nxt_s = FLUSH_RELOAD;
                        consec_nxt_s     = 8'd0;
                        flush_inc_s      = 1'b1;
                        state_nxt_s      = (FLUSH_DEPTH > 1) ? ST_FLUSH : ST_RUN;
                    end else if (eff_s == ST_FLUSH) begin
                        // Hazard stalls are meaningless while squashing.
                        ctl_s            = CTL_SQUASH;
                        flush_left_nxt_s = flush_left_r - 3'd1;
                        if (flush_left_r == 3'd1) begin
                            state_nxt_s = ST_RUN;
                        end else begin
                            state_nxt_s = ST_FLUSH;
                        end
                    end else if (hazard_stall) begin
                        ctl_s        = CTL_STALL;
                        stall_inc_s  = 1'b1;
                        consec_nxt_s = consec_r + 8'd1;
                        if ((consec_r + 8'd1) == LIMIT_8) begin
                            state_nxt_s = ST_ERROR;
                            err_set_s   = 1'b1;
                        end else begin
                            state_nxt_s = ST_STALL;
                        end
                    end else if (halt_req) begin
                        ctl_s        = CTL_DRAIN;
                        consec_nxt_s = 8'd0;
                        state_nxt_s  = ST_HALT;
                    end else begin
                        ctl_s        = CTL_RUN;
                        consec_nxt_s = 8'd0;
                        state_nxt_s  = ST_RUN;
                    end
                end
                default: begin
                    ctl_s        = CTL_RUN;
                    consec_nxt_s = 8'd0;
                    state_nxt_s  = ST_RUN;
                end
            endcase
        end
    end

    // FSM and bookkeeping registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_RUN;
            ret_r        <= ST_RUN;
            flush_left_r <= 3'd0;
            consec_r     <= 8'd0;
            error_r      <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            ret_r        <= ret_nxt_s;
            flush_left_r <= flush_left_nxt_s;
            consec_r     <= consec_nxt_s;
            error_r      <= error_r | err_set_s;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (stall_inc_s),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (flush_inc_s),
        .count (flush_count)
    );

    assign pc_write    = ctl_s.pc_write;
    assign ifid_write  = ctl_s.ifid_write;
    assign ifid_flush  = ctl_s.ifid_flush;
    assign idex_write  = ctl_s.idex_write;
    assign idex_bubble = ctl_s.idex_bubble;
    assign exmem_hold  = ctl_s.exmem_hold;
    assign state_dbg   = state_r;
    assign error       = error_r;

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Scoreboard bench for pipe_seq_ctrl: the driver pushes hand-computed
// expectations per cycle, a monitor pops and compares on the falling edge.
// Counters are built 3 bits wide so saturation is reachable.
module tb_pipe_seq_ctrl;

    localparam int CW = 3;

    localparam logic [5:0] V_RUN    = 6'b110100;
    localparam logic [5:0] V_SQUASH = 6'b111110;
    localparam logic [5:0] V_HOLD   = 6'b000001;
    localparam logic [5:0] V_STALL  = 6'b000110;
    localparam logic [5:0] V_DRAIN  = 6'b000110;
    localparam logic [5:0] V_RESET  = 6'b001110;
    localparam logic [2:0] ST_ANY   = 3'd7;

    logic          clock = 1'b0;
    logic          reset, hazard_stall, mispredict, mem_busy, halt_req, resume;
    logic          pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_hold;
    logic [2:0]    state_dbg;
    logic [CW-1:0] stall_count, flush_count;
    logic          error;

    typedef struct {
        string         nm;
        logic [5:0]    ctl;
        logic [2:0]    st;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
        logic          er;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    pipe_seq_ctrl #(.FLUSH_DEPTH(2), .STALL_LIMIT(8), .CNT_W(CW)) dut (
        .clock        (clock),
        .reset        (reset),
        .hazard_stall (hazard_stall),
        .mispredict   (mispredict),
        .mem_busy     (mem_busy),
        .halt_req     (halt_req),
        .resume       (resume),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .idex_write   (idex_write),
        .idex_bubble  (idex_bubble),
        .exmem_hold   (exmem_hold),
        .state_dbg    (state_dbg),
        .stall_count  (stall_count),
        .flush_count  (flush_count),
        .error        (error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input string fld, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s: got %0h expected %0h at %0t", nm, fld, act, exp, $time);
        end
    endtask

    // One clock of stimulus plus its expected outputs for that cycle.
    task automatic step(input string nm, input logic rst, hs, mp, mb, hr, rs,
                        input logic [5:0] ctl, input logic [2:0] st,
                        input logic [CW-1:0] sc, fc, input logic er);
        exp_t e;
        @(posedge clock);
        #1;
        reset = rst; hazard_stall = hs; mispredict = mp;
        mem_busy = mb; halt_req = hr; resume = rs;
        e.nm = nm; e.ctl = ctl; e.st = st; e.sc = sc; e.fc = fc; e.er = er;
        q.push_back(e);
    endtask

    // Monitor: compares whatever the DUT presents against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.nm, "ctl", {2'b00, pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_hold},
                    {2'b00, e.ctl});
                if (e.st != ST_ANY) begin
                    chk(e.nm, "state", {5'd0, state_dbg}, {5'd0, e.st});
                end
                chk(e.nm, "stall_cnt", 8'(stall_count), 8'(e.sc));
                chk(e.nm, "flush_cnt", 8'(flush_count), 8'(e.fc));
                chk(e.nm, "error", {7'd0, error}, {7'd0, e.er});
            end
        end
    end

    initial begin
        int wait_cyc;
        reset = 1'b1; hazard_stall = 1'b0; mispredict = 1'b0;
        mem_busy = 1'b0; halt_req = 1'b0; resume = 1'b0;
        repeat (2) @(posedge clock);

        //    name         rst hs mp mb hr rs  ctl       st      sc    fc    er
        step("reset",      1, 0, 0, 0, 0, 0, V_RESET,  3'd0,   3'd0, 3'd0, 1'b0);
        step("idle",       0, 0, 0, 0, 0, 0, V_RUN,    3'd0,   3'd0, 3'd0, 1'b0);
        step("idle",       0, 0, 0, 0, 0, 0, V_RUN,    3'd0,   3'd0, 3'd0, 1'b0);

        step("stall1",     0, 1, 0, 0, 0, 0, V_STALL,  3'd0,   3'd0, 3'd0, 1'b0);
        step("stall2",     0, 1, 0, 0, 0, 0, V_STALL,  3'd1,   3'd1, 3'd0, 1'b0);
        step("stall_end",  0, 0, 0, 0, 0, 0, V_RUN,    3'd1,   3'd2, 3'd0, 1'b0);
        step("idle",       0, 0, 0, 0, 0, 0, V_RUN,    3'd0,   3'd2, 3'd0, 1'b0);

        step("mp",         0, 0, 1, 0, 0, 0, V_SQUASH, 3'd0,   3'd2, 3'd0, 1'b0);
        step("flush_hs",   0, 1, 0, 0, 0, 0, V_SQUASH, 3'd2,   3'd2, 3'd1, 1'b0);
        step("after_fl",   0, 0, 0, 0, 0, 0, V_RUN,    3'd0,   3'd2, 3'd1, 1'b0);

        step("mp2",        0, 0, 1, 0, 0, 0, V_SQUASH, 3'd0,   3'd2, 3'd1, 1'b0);
        step("busy1",      0, 0, 0, 1, 0, 0, V_HOLD,   ST_ANY, 3'd2, 3'd2, 1'b0);
        step("busy2",      0, 0, 0, 1, 0, 0, V_HOLD,   3'd3,   3'd2, 3'd2, 1'b0);
        step("busy3",      0, 0, 0, 1, 0, 0, V_HOLD,   3'd3,   3'd2, 3'd2, 1'b0);
        step("busy4",      0, 0, 0, 1, 0, 0, V_HOLD,   3'd3,   3'd2, 3'd2, 1'b0);
        step("busy_fl",    0, 0, 0, 0, 0, 0, V_SQUASH, 3'd3,   3'd2, 3'd2, 1'b0);
        step("busy_run",   0, 0, 0, 0, 0, 0, V_RUN,    3'd0,   3'd2, 3'd2, 1'b0);

        step("mpbusy1",    0, 0, 1, 1, 0, 0, V_HOLD,   ST_ANY, 3'd2, 3'd2, 1'b0);
        step("mpbusy2",    0, 0, 1, 1, 0, 0, V_HOLD,   3'd3,   3'd2, 3'd2, 1'b0);
        step("mp_free",    0, 0, 1, 0, 0, 0, V_SQUASH, 3'd3,   3'd2, 3'd2, 1'b0);
        step("mp_flush",   0, 0, 0, 0, 0, 0, V_SQUASH, 3'd2,   3'd2, 3'd3, 1'b0);
        step("mp_run",     0, 0, 0, 0, 0, 0, V_RUN,    3'd0,   3'd2, 3'd3, 1'b0);

        step("halt_req",   0, 0, 0, 0, 1, 0, V_DRAIN,  3'd0,   3'd2, 3'd3, 1'b0);
        step("halt",       0, 0, 0, 0, 0, 0, V_DRAIN,  3'd4,   3'd2, 3'd3, 1'b0);
        step("halt_mp",    0, 0, 1, 0, 0, 0, V_DRAIN,  3'd4,   3'd2, 3'd3, 1'b0);
        step("halt_hs",    0, 1, 0, 0, 0, 0, V_DRAIN,  3'd4,   3'd2, 3'd3, 1'b0);
        step("resume",     0, 0, 0, 0, 0, 1, V_DRAIN,  3'd4,   3'd2, 3'd3, 1'b0);
        step("resumed",    0, 0, 0, 0, 0, 0, V_RUN,    3'd0,   3'd2, 3'd3, 1'b0);

        step("rfl_mp",     0, 0, 1, 0, 0, 0, V_SQUASH, 3'd0,   3'd2, 3'd3, 1'b0);
        step("rfl_rst1",   1, 0, 0, 0, 0, 0, V_RESET,  3'd2,   3'd2, 3'd4, 1'b0);
        step("rfl_rst2",   1, 0, 0, 0, 0, 0, V_RESET,  3'd0,   3'd0, 3'd0, 1'b0);
        step("rfl_rst3",   1, 0, 0, 0, 0, 0, V_RESET,  3'd0,   3'd0, 3'd0, 1'b0);
        step("rfl_run",    0, 0, 0, 0, 0, 0, V_RUN,    3'd0,   3'd0, 3'd0, 1'b0);

        // Eight consecutive stalls; the 3-bit stall counter reaches 7 and sticks.
        for (int k = 1; k <= 8; k++) begin
            step("stall_lim", 0, 1, 0, 0, 0, 0, V_STALL, (k == 1) ? 3'd0 : 3'd1,
                 3'(k - 1), 3'd0, 1'b0);
        end
        step("err",        0, 1, 0, 0, 0, 1, V_DRAIN,  3'd5,   3'd7, 3'd0, 1'b1);
        step("err_ign",    0, 0, 1, 0, 0, 1, V_DRAIN,  3'd5,   3'd7, 3'd0, 1'b1);
        step("err_rst",    1, 0, 0, 0, 0, 0, V_RESET,  3'd5,   3'd7, 3'd0, 1'b1);
        step("err_clr",    0, 0, 0, 0, 0, 0, V_RUN,    3'd0,   3'd0, 3'd0, 1'b0);

        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 10) begin
            @(posedge clock);
            wait_cyc++;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_seq_ctrl.md
Name: pipe_seq_ctrl

Overview:
- Central pipeline sequencer for the 16-bit 5-stage pipeline.
- Inputs: the hazard detector's stall request, the branch-resolution mispredict flag, the data-memory busy flag and a halt request.
- Outputs: per-stage register enables, flush/bubble controls and the PC write enable.
- Arbitrates these events by fixed priority and sequences multi-cycle flushes, memory waits and halt/drain.

Parameters:
- FLUSH_DEPTH, 2, cycles IF/ID and ID/EX are squashed per mispredict (range 1..7).
- STALL_LIMIT, 8, consecutive hazard-stall cycles that trigger error (range 2..255).
- CNT_W, 16, width of the performance counters.

Ports:
- clock  in  1  system clock, all state updates on posedge.
- reset  in  1  synchronous, active-high.
- hazard_stall  in  1  RAW/load-use stall request (combinational, same cycle).
- mispredict  in  1  branch resolved against the prediction; PC mux already selects the correct target.
- mem_busy  in  1  data memory multi-cycle access in progress.
- halt_req  in  1  HALT instruction decoded in ID.
- resume  in  1  leave HALT.
- pc_write  out  1  PC register enable.
- ifid_write  out  1  IF/ID register enable.
- ifid_flush  out  1  load NOP into IF/ID.
- idex_write  out  1  ID/EX register enable.
- idex_bubble  out  1  load NOP/zero controls into ID/EX.
- exmem_hold  out  1  freeze EX/MEM and MEM/WB.
- state_dbg  out  3  current FSM state encoding.
- stall_count  out  CNT_W  total hazard-stall cycles, saturating.
- flush_count  out  CNT_W  total mispredict events, saturating.
- error  out  1  sticky stall-limit violation.

Behaviour:
- Registered state: state, ret_state, flush_left[2:0], consec[7:0], counters, error. Control outputs are combinational from state and inputs, same cycle.
- States: RUN=0, STALL=1, FLUSH=2, MEMWAIT=3, HALT=4, ERROR=5.
- Output defaults: the RUN set is pc_write=1, ifid_write=1, idex_write=1, all other controls 0.
- Reset high:
  - Outputs forced to pc_write=0, ifid_write=0, idex_write=1, ifid_flush=1, idex_bubble=1, exmem_hold=0.
  - Next state RUN; ret_state, flush_left, consec, counters and error cleared.
  - Reset mid-FLUSH/MEMWAIT/HALT/ERROR behaves identically.
- Priority (highest first): mem_busy > mispredict > FLUSH in progress > hazard_stall > halt_req.
- ERROR and HALT ignore everything except mem_busy, resume (HALT only) and reset.
- mem_busy=1, any state:
  - Outputs: pc_write=0, ifid_write=0, idex_write=0, idex_bubble=0, ifid_flush=0, exmem_hold=1.
  - Entering MEMWAIT from state S saves ret_state=S; STALL saves as RUN.
  - flush_left and consec are frozen while busy.
  - mem_busy=0 in MEMWAIT: apply ret_state's rules this cycle; next state per those rules. A pending mispredict is therefore acted on in the first non-busy cycle.
- mispredict=1 in RUN/STALL/FLUSH:
  - Outputs: pc_write=1, ifid_write=1, ifid_flush=1, idex_write=1, idex_bubble=1.
  - flush_left<=FLUSH_DEPTH-1; consec<=0; flush_count+1.
  - Next FLUSH if FLUSH_DEPTH>1, else RUN.
  - A mispredict arriving inside FLUSH restarts the count.
- FLUSH, no higher event:
  - Outputs: the same squash set as mispredict; hazard_stall is ignored.
  - flush_left-1; when flush_left==1 next RUN.
- hazard_stall=1 in RUN/STALL:
  - Outputs: pc_write=0, ifid_write=0, idex_write=1, idex_bubble=1.
  - stall_count+1; consec+1; next STALL.
  - When consec+1==STALL_LIMIT: next ERROR, error<=1.
- hazard_stall=0 in STALL: RUN outputs, consec<=0, next RUN.
- halt_req=1 in RUN/STALL, no higher event:
  - Outputs: pc_write=0, ifid_write=0, idex_bubble=1; next HALT.
- HALT:
  - Outputs: pc_write=0, ifid_write=0, idex_write=1, idex_bubble=1, exmem_hold=0, so the pipeline drains.
  - resume=1: outputs stay as HALT this cycle; next RUN.
- ERROR: same outputs as HALT; exits only on reset; error stays 1.
- Counters saturate at all-ones and never wrap.
- state_dbg = state; it reads MEMWAIT while busy.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state encodings (RUN..ERROR, 3 bits);
  - the RUN/SQUASH/HOLD/STALL/DRAIN output-vector constants;
  - the default FLUSH_DEPTH and STALL_LIMIT.
- One sub-module, sat_counter (parameter W; inputs clock, reset, inc; output count, saturating). It is instantiated for stall_count and flush_count.

Test Plan:
- Reset, then idle RUN: pc_write=1, ifid_write=1, idex_write=1, rest 0, state_dbg=0.
- Reset held 3 cycles mid-FLUSH: outputs ifid_flush=1, idex_bubble=1, pc_write=0; after release state_dbg=0, counters 0.
- hazard_stall high 2 cycles: pc_write=ifid_write=0, idex_bubble=1 both cycles; stall_count=2; RUN outputs on the 3rd cycle.
- hazard_stall held 8 cycles (STALL_LIMIT=8): error=1 and state_dbg=5 from cycle 9; resume has no effect; reset clears.
- Mispredict pulse with FLUSH_DEPTH=2: squash outputs for 2 cycles; flush_count=1; hazard_stall asserted in cycle 2 is ignored.
- mem_busy 4 cycles beginning at the FLUSH cycle:
  - exmem_hold=1, all enables 0, state_dbg=3 during the wait;
  - then 1 FLUSH squash cycle, then RUN.
- Mispredict and mem_busy together: hold first; squash on the first non-busy cycle.
- halt_req in RUN: drain outputs; state_dbg=4 until resume=1; RUN on the following cycle.
